// File: rtl/cordic_result_normalizer_pkg.sv
// Shared constants and types for the CORDIC result normaliser (fixed Q1.20 to IEEE-754 single).
package cordic_result_normalizer_pkg;

  localparam int unsigned FIX_W    = 21;
  localparam int unsigned FRAC_W   = 20;
  localparam int unsigned EXP_BIAS = 127;
  localparam int unsigned FP_W     = 32;
  localparam int unsigned EXP_W    = 8;
  localparam int unsigned MANT_W   = 23;
  localparam int unsigned NIB_W    = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [FP_W-1:0] FP_ZERO = '0;

endpackage

// File: rtl/cordic_result_normalizer.sv
// Iterative coarse/fine left-shift normaliser: unsigned Q1.20 magnitude + sign in,
// IEEE-754 single out over valid/ready. One transaction in flight at a time.
module cordic_result_normalizer
  import cordic_result_normalizer_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FIX_W-1:0]  in_fixed,
  input  logic              in_sign,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FP_W-1:0]   result_fp
);

  localparam int unsigned PAD_W = MANT_W - FRAC_W;

  state_e             r_state;
  state_e             w_state_next;
  logic [FIX_W-1:0]   r_m;
  logic [EXP_W-1:0]   r_e;
  logic               r_s;
  logic               r_z;
  logic [FP_W-1:0]    r_result;
  logic               r_in_ready;
  logic               r_out_valid;
  logic               w_in_ready_d;
  logic               w_out_valid_d;
  logic               w_nib_zero;

  assign w_nib_zero = (r_m[FIX_W-1 -: NIB_W] == '0);

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result_fp = r_result;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else if (clk_en) begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_state_next = NORM;
      NORM:    if (r_z || r_m[FIX_W-1]) w_state_next = DONE;
      DONE:    if (out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Handshake flags are registered from the next state so they track r_state exactly.
  always_comb begin
    w_in_ready_d  = 1'b0;
    w_out_valid_d = 1'b0;
    w_in_ready_d  = (w_state_next == IDLE);
    w_out_valid_d = (w_state_next == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_m         <= '0;
      r_e         <= '0;
      r_s         <= 1'b0;
      r_z         <= 1'b0;
      r_result    <= FP_ZERO;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else if (clk_en) begin
      r_in_ready  <= w_in_ready_d;
      r_out_valid <= w_out_valid_d;
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_m <= in_fixed;
            r_e <= EXP_W'(EXP_BIAS);
            r_s <= in_sign;
            r_z <= (in_fixed == '0);
          end
        end
        NORM: begin
          // Zero wins over sign so a negative zero still encodes as +0.
          if (r_z) begin
            r_result <= FP_ZERO;
          end else if (r_m[FIX_W-1]) begin
            r_result <= {r_s, r_e, r_m[FRAC_W-1:0], PAD_W'(0)};
          end else if (w_nib_zero) begin
            r_m <= r_m << NIB_W;
            r_e <= r_e - EXP_W'(NIB_W);
          end else begin
            r_m <= r_m << 1;
            r_e <= r_e - EXP_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
